// File: rtl/stack_pkg.sv
// Shared codes and state type for the call/interrupt stack unit.
package stack_pkg;

    localparam logic [19:0] SP_TOP_DEFAULT = 20'hFFFFF;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b11;

    localparam logic [1:0] PH_NONE   = 2'b00;
    localparam logic [1:0] PH_FIRST  = 2'b11;
    localparam logic [1:0] PH_SECOND = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALL2 = 2'd1,
        INT2  = 2'd2,
        RET2  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sp_reg.sv
// 20-bit stack pointer; stack grows downward from SP_TOP, wraps mod 2^20.
module sp_reg
    import stack_pkg::*;
#(
    parameter logic [19:0] SP_TOP = SP_TOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    output logic [19:0] sp,
    output logic [19:0] sp_inc,
    output logic        overflow,
    output logic        underflow
);

    assign sp_inc    = sp + 20'd1;
    assign overflow  = (sp == 20'd0);
    assign underflow = (sp == SP_TOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= SP_TOP;
        end else if (push && !overflow) begin
            sp <= sp - 20'd1;
        end else if (pop && !underflow) begin
            sp <= sp_inc;
        end
    end

endmodule

// File: rtl/stack_unit.sv
// Stack access unit: plain PUSH/POP plus two-cycle CALL/INT/RET(RTI) sequences.
// state | meaning: IDLE idle/plain ops | CALL2 wait CALL hi-half | INT2 wait INT hi-half | RET2 wait RET low-half
module stack_unit
    import stack_pkg::*;
#(
    parameter logic [19:0] SP_TOP = SP_TOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  enablePushOrPop,
    input  logic [1:0]  firstTimeCall,
    input  logic [1:0]  firstTimeRET,
    input  logic [1:0]  firstTimeINT,
    input  logic        isRTI,
    input  logic [31:0] pcIn,
    input  logic [15:0] dataIn,
    input  logic [2:0]  ccrIn,
    input  logic [15:0] memRdata,
    output logic [19:0] memAddr,
    output logic        memWrite,
    output logic        memRead,
    output logic [15:0] memWdata,
    output logic [15:0] popData,
    output logic [31:0] pcOut,
    output logic        pcLoad,
    output logic [2:0]  ccrOut,
    output logic        ccrLoad,
    output logic        stackErr,
    output logic        protoErr
);

    seq_state_t  state, state_next;
    logic [31:0] ret_addr;
    logic [15:0] hi_half;
    logic [2:0]  frozen_ccr;
    logic        rti;

    logic [19:0] sp, sp_inc;
    logic        overflow, underflow;
    logic        push_req, pop_req, do_push, do_pop;
    logic        is_push, is_pop, proto_err, stack_fault;
    logic        latch_call, latch_int, latch_ret, finish_ret, plain_pop;
    logic [31:0] pc_plus1;
    logic [15:0] wdata;

    assign pc_plus1 = pcIn + 32'd1;
    assign is_push  = (enablePushOrPop == OP_PUSH);
    assign is_pop   = (enablePushOrPop == OP_POP);

    sp_reg #(.SP_TOP(SP_TOP)) u_sp (
        .clk       (clk),
        .rst       (rst),
        .push      (do_push),
        .pop       (do_pop),
        .sp        (sp),
        .sp_inc    (sp_inc),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        pop_req    = 1'b0;
        wdata      = dataIn;
        proto_err  = 1'b0;
        latch_call = 1'b0;
        latch_int  = 1'b0;
        latch_ret  = 1'b0;
        finish_ret = 1'b0;
        plain_pop  = 1'b0;
        // Phase priority INT > CALL > RET; anything not exactly legal is a protocol error.
        if (firstTimeINT != PH_NONE) begin
            if (firstTimeINT == PH_FIRST && state == IDLE && is_push) begin
                push_req   = 1'b1;
                wdata      = pcIn[15:0];
                latch_int  = 1'b1;
                state_next = INT2;
            end else if (firstTimeINT == PH_SECOND && state == INT2 && is_push) begin
                push_req   = 1'b1;
                wdata      = ret_addr[31:16];
                state_next = IDLE;
            end else begin
                proto_err = 1'b1;
            end
        end else if (firstTimeCall != PH_NONE) begin
            if (firstTimeCall == PH_FIRST && state == IDLE && is_push) begin
                push_req   = 1'b1;
                wdata      = pc_plus1[15:0];
                latch_call = 1'b1;
                state_next = CALL2;
            end else if (firstTimeCall == PH_SECOND && state == CALL2 && is_push) begin
                push_req   = 1'b1;
                wdata      = ret_addr[31:16];
                state_next = IDLE;
            end else begin
                proto_err = 1'b1;
            end
        end else if (firstTimeRET != PH_NONE) begin
            if (firstTimeRET == PH_FIRST && state == IDLE && is_pop) begin
                pop_req    = 1'b1;
                latch_ret  = 1'b1;
                state_next = RET2;
            end else if (firstTimeRET == PH_SECOND && state == RET2 && is_pop) begin
                pop_req    = 1'b1;
                finish_ret = 1'b1;
                state_next = IDLE;
            end else begin
                proto_err = 1'b1;
            end
        end else if (state == IDLE) begin
            push_req  = is_push;
            pop_req   = is_pop;
            plain_pop = is_pop;
        end
        stack_fault = (push_req && overflow) || (pop_req && underflow);
        if (stack_fault) begin
            state_next = IDLE;
        end
    end

    assign do_push  = push_req && !overflow;
    assign do_pop   = pop_req && !underflow;
    assign memWrite = do_push;
    assign memRead  = do_pop;
    assign memAddr  = do_pop ? sp_inc : sp;
    assign memWdata = wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ret_addr   <= 32'd0;
            hi_half    <= 16'd0;
            frozen_ccr <= 3'd0;
            rti        <= 1'b0;
            pcOut      <= 32'd0;
            pcLoad     <= 1'b0;
            ccrOut     <= 3'd0;
            ccrLoad    <= 1'b0;
            stackErr   <= 1'b0;
            protoErr   <= 1'b0;
            popData    <= 16'd0;
        end else begin
            state    <= state_next;
            pcLoad   <= 1'b0;
            ccrLoad  <= 1'b0;
            protoErr <= proto_err;
            stackErr <= stackErr | stack_fault;
            if (latch_call && do_push) begin
                ret_addr <= pc_plus1;
            end
            if (latch_int && do_push) begin
                ret_addr   <= pcIn;
                frozen_ccr <= ccrIn;
            end
            if (latch_ret && do_pop) begin
                hi_half <= memRdata;
                rti     <= isRTI;
            end
            if (finish_ret && do_pop) begin
                pcOut  <= {hi_half, memRdata};
                pcLoad <= 1'b1;
                if (rti) begin
                    ccrOut  <= frozen_ccr;
                    ccrLoad <= 1'b1;
                end
            end
            if (plain_pop && do_pop) begin
                popData <= memRdata;
            end
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Directed and randomized checks of stack_unit against a queue-based stack model.
module tb_stack_unit;
    import stack_pkg::*;

    localparam logic [19:0] TOP = 20'hFFFFF;

    logic        clk, rst;
    logic [1:0]  en, ftc, ftr, fti;
    logic        is_rti;
    logic [31:0] pc_in;
    logic [15:0] data_in;
    logic [2:0]  ccr_in;
    logic [15:0] mem_rdata;
    logic [19:0] mem_addr;
    logic        mem_write, mem_read;
    logic [15:0] mem_wdata, pop_data;
    logic [31:0] pc_out;
    logic        pc_load, ccr_load, stack_err, proto_err;
    logic [2:0]  ccr_out;

    logic [15:0] mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] stk[$];
    logic [2:0]  frozen;
    bit          exp_serr;
    logic [31:0] exp_pc;
    bit          exp_ccr_load;
    logic [2:0]  exp_ccr;

    stack_unit dut (
        .clk(clk), .rst(rst), .enablePushOrPop(en),
        .firstTimeCall(ftc), .firstTimeRET(ftr), .firstTimeINT(fti),
        .isRTI(is_rti), .pcIn(pc_in), .dataIn(data_in), .ccrIn(ccr_in),
        .memRdata(mem_rdata), .memAddr(mem_addr), .memWrite(mem_write),
        .memRead(mem_read), .memWdata(mem_wdata), .popData(pop_data),
        .pcOut(pc_out), .pcLoad(pc_load), .ccrOut(ccr_out), .ccrLoad(ccr_load),
        .stackErr(stack_err), .protoErr(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;

    initial begin
        #400000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] e, c, r, i, input logic rt,
                         input logic [31:0] pc, input logic [15:0] d, input logic [2:0] cc);
        en = e; ftc = c; ftr = r; fti = i; is_rti = rt;
        pc_in = pc; data_in = d; ccr_in = cc;
    endtask

    // One clock of stimulus: combinational memory-port checks, then registered outputs.
    task automatic step(input string tag, input logic [1:0] e, c, r, i, input logic rt,
                        input logic [31:0] pc, input logic [15:0] d, input logic [2:0] cc,
                        input bit ew, input bit er, input logic [19:0] ea,
                        input logic [15:0] ewd, input bit eproto, input bit eload);
        drive(e, c, r, i, rt, pc, d, cc);
        #2;
        chk({tag, ":wr"}, {31'd0, mem_write}, {31'd0, ew});
        chk({tag, ":rd"}, {31'd0, mem_read}, {31'd0, er});
        if (ew || er) chk({tag, ":addr"}, {12'd0, mem_addr}, {12'd0, ea});
        if (ew) chk({tag, ":wdata"}, {16'd0, mem_wdata}, {16'd0, ewd});
        @(posedge clk);
        #1;
        chk({tag, ":proto"}, {31'd0, proto_err}, {31'd0, eproto});
        chk({tag, ":serr"}, {31'd0, stack_err}, {31'd0, exp_serr});
        chk({tag, ":pcload"}, {31'd0, pc_load}, {31'd0, eload});
        if (eload) begin
            chk({tag, ":pcout"}, pc_out, exp_pc);
            chk({tag, ":ccrload"}, {31'd0, ccr_load}, {31'd0, exp_ccr_load});
            if (exp_ccr_load) chk({tag, ":ccrout"}, {29'd0, ccr_out}, {29'd0, exp_ccr});
        end else begin
            chk({tag, ":ccrload"}, {31'd0, ccr_load}, 32'd0);
        end
    endtask

    task automatic idle(input string tag);
        step(tag, OP_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [19:0] sp_now();
        return TOP - 20'(stk.size());
    endfunction

    initial begin
        int kind, nst, v;
        logic [31:0] pc, ret;
        logic [15:0] d, lo, hi;
        logic [2:0]  cc;
        logic [1:0]  nc, nr;
        bit          rt;

        for (int k = 0; k < 1024; k++) mem[k] = 16'h0;
        drive(OP_NONE, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        exp_serr = 0; exp_ccr_load = 0; exp_pc = 0; exp_ccr = 0; frozen = 3'd0;
        #23;
        chk("rst:pcout", pc_out, 32'd0);
        chk("rst:pcload", {31'd0, pc_load}, 32'd0);
        chk("rst:ccrout", {29'd0, ccr_out}, 32'd0);
        chk("rst:ccrload", {31'd0, ccr_load}, 32'd0);
        chk("rst:serr", {31'd0, stack_err}, 32'd0);
        chk("rst:proto", {31'd0, proto_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        step("push", OP_PUSH, 0, 0, 0, 0, 0, 16'hABCD, 0, 1, 0, 20'hFFFFF, 16'hABCD, 0, 0);
        step("push_sp", OP_PUSH, 0, 0, 0, 0, 0, 16'h1111, 0, 1, 0, 20'hFFFFE, 16'h1111, 0, 0);
        step("pop1", OP_POP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20'hFFFFE, 0, 0, 0);
        chk("pop1:data", {16'd0, pop_data}, 32'h1111);
        step("pop2", OP_POP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20'hFFFFF, 0, 0, 0);
        chk("pop2:data", {16'd0, pop_data}, 32'hABCD);

        step("call1", OP_PUSH, PH_FIRST, 0, 0, 0, 32'h0001_FFFF, 16'h7777, 0, 1, 0, 20'hFFFFF, 16'h0000, 0, 0);
        idle("call_stall");
        step("call2", OP_PUSH, PH_SECOND, 0, 0, 0, 0, 16'h7777, 0, 1, 0, 20'hFFFFE, 16'h0002, 0, 0);
        step("ret1", OP_POP, 0, PH_FIRST, 0, 0, 0, 0, 0, 0, 1, 20'hFFFFE, 0, 0, 0);
        idle("ret_stall");
        exp_pc = 32'h0002_0000; exp_ccr_load = 0;
        step("ret2", OP_POP, 0, PH_SECOND, 0, 0, 0, 0, 0, 0, 1, 20'hFFFFF, 0, 0, 1);
        idle("ret_after");

        step("int1", OP_PUSH, 0, 0, PH_FIRST, 0, 32'h0000_0123, 0, 3'b101, 1, 0, 20'hFFFFF, 16'h0123, 0, 0);
        step("int2", OP_PUSH, 0, 0, PH_SECOND, 0, 0, 0, 3'b010, 1, 0, 20'hFFFFE, 16'h0000, 0, 0);
        step("rti1", OP_POP, 0, PH_FIRST, 0, 1, 0, 0, 0, 0, 1, 20'hFFFFE, 0, 0, 0);
        exp_pc = 32'h0000_0123; exp_ccr_load = 1; exp_ccr = 3'b101;
        step("rti2", OP_POP, 0, PH_SECOND, 0, 0, 0, 0, 0, 0, 1, 20'hFFFFF, 0, 0, 1);
        frozen = 3'b101;

        step("proto", OP_PUSH, PH_SECOND, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle("proto_clr");
        step("sp_kept", OP_PUSH, 0, 0, 0, 0, 0, 16'h5555, 0, 1, 0, 20'hFFFFF, 16'h5555, 0, 0);
        step("sp_kept_pop", OP_POP, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20'hFFFFF, 0, 0, 0);

        exp_serr = 1;
        step("underflow", OP_POP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("serr_sticky");

        step("rcall1", OP_PUSH, PH_FIRST, 0, 0, 0, 32'h0000_1000, 0, 0, 1, 0, 20'hFFFFF, 16'h1001, 0, 0);
        drive(OP_PUSH, 0, 0, 0, 0, 0, 16'h2222, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid:addr", {12'd0, mem_addr}, {12'd0, TOP});
        chk("rst_mid:wr", {31'd0, mem_write}, 32'd1);
        chk("rst_mid:serr", {31'd0, stack_err}, 32'd0);
        drive(OP_NONE, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_serr = 0; frozen = 3'd0;
        step("rcall2", OP_PUSH, PH_SECOND, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle("rst_nopc");

        stk.delete();
        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 5);
            if (kind == 4 && stk.size() < 2) kind = 2;
            case (kind)
                0: begin
                    d = 16'($urandom);
                    step("r_push", OP_PUSH, 0, 0, 0, 0, 0, d, 0, 1, 0, sp_now(), d, 0, 0);
                    stk.push_back(d);
                end
                1: begin
                    if (stk.size() == 0) begin
                        exp_serr = 1;
                        step("r_unflow", OP_POP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    end else begin
                        lo = stk[$];
                        step("r_pop", OP_POP, 0, 0, 0, 0, 0, 0, 0, 0, 1, sp_now() + 20'd1, 0, 0, 0);
                        void'(stk.pop_back());
                        chk("r_pop:data", {16'd0, pop_data}, {16'd0, lo});
                    end
                end
                2, 3: begin
                    pc = $urandom; cc = 3'($urandom);
                    ret = (kind == 2) ? pc + 32'd1 : pc;
                    nc = (kind == 3) ? 2'($urandom) : 2'b00;
                    nr = (kind == 3) ? 2'($urandom) : 2'b00;
                    if (kind == 2)
                        step("r_call1", OP_PUSH, PH_FIRST, 0, 0, 0, pc, 0, cc, 1, 0, sp_now(), ret[15:0], 0, 0);
                    else
                        step("r_int1", OP_PUSH, nc, nr, PH_FIRST, 0, pc, 0, cc, 1, 0, sp_now(), ret[15:0], 0, 0);
                    stk.push_back(ret[15:0]);
                    if (kind == 3) frozen = cc;
                    nst = $urandom_range(0, 2);
                    for (int s = 0; s < nst; s++) begin
                        if ($urandom_range(0, 1) == 0)
                            step("r_wstall", 2'($urandom), 0, 0, 0, 0, $urandom, 16'($urandom), 0, 0, 0, 0, 0, 0, 0);
                        else if (kind == 2)
                            step("r_cbad", OP_PUSH, PH_FIRST, 0, 0, 0, $urandom, 0, 0, 0, 0, 0, 0, 1, 0);
                        else
                            step("r_ibad", OP_PUSH, 0, 0, PH_FIRST, 0, $urandom, 0, 3'($urandom), 0, 0, 0, 0, 1, 0);
                    end
                    if (kind == 2)
                        step("r_call2", OP_PUSH, PH_SECOND, 0, 0, 0, $urandom, 0, 0, 1, 0, sp_now(), ret[31:16], 0, 0);
                    else
                        step("r_int2", OP_PUSH, 2'($urandom), 2'($urandom), PH_SECOND, 0, $urandom, 0, 3'($urandom), 1, 0, sp_now(), ret[31:16], 0, 0);
                    stk.push_back(ret[31:16]);
                end
                4: begin
                    rt = 1'($urandom);
                    hi = stk[$];
                    step("r_ret1", OP_POP, 0, PH_FIRST, 0, rt, 0, 0, 0, 0, 1, sp_now() + 20'd1, 0, 0, 0);
                    void'(stk.pop_back());
                    nst = $urandom_range(0, 2);
                    for (int s = 0; s < nst; s++) begin
                        if ($urandom_range(0, 1) == 0)
                            step("r_rstall", 2'($urandom), 0, 0, 0, 1'($urandom), 0, 0, 0, 0, 0, 0, 0, 0, 0);
                        else
                            step("r_rbad", OP_POP, 0, PH_FIRST, 0, 1'($urandom), 0, 0, 0, 0, 0, 0, 0, 1, 0);
                    end
                    lo = stk[$];
                    exp_pc = {hi, lo}; exp_ccr_load = rt; exp_ccr = frozen;
                    step("r_ret2", OP_POP, 0, PH_SECOND, 0, 1'($urandom), 0, 0, 0, 0, 1, sp_now() + 20'd1, 0, 0, 1);
                    void'(stk.pop_back());
                end
                default: begin
                    v = $urandom_range(0, 5);
                    case (v)
                        0: step("r_ill", OP_PUSH, PH_SECOND, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                        1: step("r_ill", OP_PUSH, 0, 0, PH_SECOND, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                        2: step("r_ill", OP_POP, 0, PH_SECOND, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                        3: step("r_ill", OP_POP, PH_FIRST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                        4: step("r_ill", OP_PUSH, 0, PH_FIRST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                        default: step("r_ill", OP_NONE, 0, 0, PH_FIRST, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                    endcase
                end
            endcase
        end
        idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter SP_TOP, default 20'hFFFFF, the stack pointer value after reset (empty stack).
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 enablePushOrPop  in  2  00 none, 01 push, 11 pop, 10 illegal (treated as none).
REQ-005 firstTimeCall, firstTimeRET, firstTimeINT  in  2 each  sequence phase: 11 first cycle, 01 second cycle, 00 none.
REQ-006 isRTI  in  1  qualifies a RET sequence as RTI.
REQ-007 pcIn  in  32  PC of the instruction in this stage; dataIn  in  16  PUSH operand; ccrIn  in  3  current flags.
REQ-008 memRdata  in  16  data memory read data, combinational on memAddr.
REQ-009 memAddr  out  20; memWrite  out  1; memRead  out  1; memWdata  out  16.
REQ-010 popData  out  16  plain POP result, equals memRdata.
REQ-011 pcOut  out  32; pcLoad  out  1; ccrOut  out  3; ccrLoad  out  1; stackErr  out  1; protoErr  out  1.

Function
REQ-012 SP SHALL be 20-bit; push: memAddr=SP, memWrite=1, SP<=SP-1; pop: memAddr=SP+1, memRead=1, SP<=SP+1; all arithmetic mod 2^20.
REQ-013 memAddr/memRead/memWrite/memWdata SHALL be combinational from inputs and state; all other outputs registered.
REQ-014 Sequence FSM states: IDLE, CALL2, INT2, RET2; priority when several phase inputs nonzero: INT > CALL > RET.
REQ-015 IDLE, firstTimeCall=11 with push: latch retAddr=pcIn+1, write (pcIn+1)[15:0], go CALL2.
REQ-016 CALL2, firstTimeCall=01 with push: write retAddr[31:16], go IDLE.
REQ-017 IDLE, firstTimeINT=11 with push: latch retAddr=pcIn and frozenCcr=ccrIn, write pcIn[15:0], go INT2.
REQ-018 INT2, firstTimeINT=01 with push: write retAddr[31:16], go IDLE.
REQ-019 IDLE, firstTimeRET=11 with pop: latch hiHalf=memRdata, latch rti=isRTI, go RET2.
REQ-020 RET2, firstTimeRET=01 with pop: next cycle pcOut={hiHalf,memRdata}, pcLoad=1 for exactly one cycle; if rti also ccrOut=frozenCcr, ccrLoad=1 same cycle; go IDLE.
REQ-021 Plain push/pop (all phases 00) SHALL be accepted only in IDLE; memWdata=dataIn for push.
REQ-022 Phase 01 not matching current state, phase 11 outside IDLE, or phase input with mismatched enablePushOrPop: no memory access, SP unchanged, state unchanged, protoErr=1 for one cycle.
REQ-023 In CALL2/INT2/RET2, all-zero phase inputs SHALL hold state (stall) with no memory access.
REQ-024 Push with SP==0 (overflow) or pop with SP==SP_TOP (underflow): no access, SP unchanged, sequence aborted to IDLE, stackErr set sticky until reset.
REQ-025 frozenCcr SHALL persist across later CALL/RET sequences until the next INT first phase.

Reset
REQ-026 While rst=1 and asynchronously on assertion: SP=SP_TOP, state=IDLE, retAddr=0, hiHalf=0, frozenCcr=0, rti=0, pcOut=0, pcLoad=0, ccrOut=0, ccrLoad=0, stackErr=0, protoErr=0.
REQ-027 Reset mid-sequence SHALL discard the partial sequence; no pcLoad produced for it.

Structure
REQ-028 Shared package stack_pkg SHALL hold SP_TOP default, push/pop codes (NONE, PUSH, POP) and phase codes (FIRST=11, SECOND=01), and the FSM state enum.
REQ-029 SP register with inc/dec/overflow/underflow detection SHALL be a sub-module sp_reg; FSM and latches stay in stack_unit.

Verification
REQ-030 PUSH dataIn=16'hABCD after reset -> memAddr=20'hFFFFF, memWrite=1, memWdata=16'hABCD; SP=20'hFFFFE.
REQ-031 CALL pcIn=32'h0001_FFFF (11 then 01) -> writes 16'h0000 at FFFFF, 16'h0002 at FFFFE; SP=FFFFD.
REQ-032 Following RET (11 then 01) -> reads FFFFE then FFFFF; one cycle later pcOut=32'h0002_0000, pcLoad=1, ccrLoad=0; SP=FFFFF.
REQ-033 INT pcIn=32'h0000_0123, ccrIn=3'b101, then RTI -> pcOut=32'h0000_0123, ccrOut=3'b101, pcLoad=ccrLoad=1 same cycle.
REQ-034 POP at reset SP -> no memRead, stackErr=1 sticky; firstTimeCall=01 in IDLE -> protoErr pulse, SP unchanged.
REQ-035 rst asserted in CALL2 -> state IDLE, SP=FFFFF immediately; subsequent 01 phase -> protoErr.
